// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: one req/ack bus access per load/store,
// with RV32I byte-lane alignment, load extension, misalignment and timeout errors.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall_out,
    output logic        done_out,
    output logic [31:0] rdata_out,
    output logic        err_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [7:0] LP_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wmask;
    logic        r_is_load;
    logic [2:0]  r_f3;
    logic [1:0]  r_lane;
    logic        r_err;
    logic [31:0] r_rdata;

    logic        w_start;
    logic        w_illegal;
    logic        w_launch;
    logic        w_fin;
    logic        w_fail;
    logic [31:0] w_rdata_nxt;
    logic [31:0] w_st_wdata;
    logic [3:0]  w_st_wmask;
    logic [31:0] w_ld_data;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_start = valid_in & (mem_read_in | mem_write_in);

    always_comb begin
        w_illegal = 1'b0;
        if (mem_read_in & mem_write_in)
            w_illegal = 1'b1;
        if (funct3_in == 3'b011 || funct3_in == 3'b110 || funct3_in == 3'b111)
            w_illegal = 1'b1;
        if (mem_write_in & funct3_in[2])
            w_illegal = 1'b1;
        if (funct3_in[1:0] == 2'b01 && addr_in[0])
            w_illegal = 1'b1;
        if (funct3_in[1:0] == 2'b10 && addr_in[1:0] != 2'b00)
            w_illegal = 1'b1;
    end

    // Store lane replication; loads present an idle write side.
    always_comb begin
        w_st_wdata = 32'h0;
        w_st_wmask = 4'h0;
        if (mem_write_in) begin
            unique case (funct3_in[1:0])
                2'b00: begin
                    w_st_wdata = {4{wdata_in[7:0]}};
                    w_st_wmask = 4'b0001 << addr_in[1:0];
                end
                2'b01: begin
                    w_st_wdata = {2{wdata_in[15:0]}};
                    w_st_wmask = addr_in[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    w_st_wdata = wdata_in;
                    w_st_wmask = 4'b1111;
                end
            endcase
        end
    end

    always_comb begin
        w_byte = mem_rdata[7:0];
        unique case (r_lane)
            2'd0: w_byte = mem_rdata[7:0];
            2'd1: w_byte = mem_rdata[15:8];
            2'd2: w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (r_f3)
            3'b000: w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b100: w_ld_data = {24'h0, w_byte};
            3'b001: w_ld_data = {{16{w_half[15]}}, w_half};
            3'b101: w_ld_data = {16'h0, w_half};
            default: w_ld_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_launch    = 1'b0;
        w_fin       = 1'b0;
        w_fail      = 1'b0;
        w_rdata_nxt = 32'h0;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if (w_illegal) begin
                        w_next = S_DONE;
                        w_fail = 1'b1;
                    end else begin
                        w_next   = S_WAIT;
                        w_launch = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // An ack on the last allowed cycle still wins over the timeout.
                if (mem_ack) begin
                    w_next = S_DONE;
                    w_fin  = 1'b1;
                    if (r_is_load)
                        w_rdata_nxt = w_ld_data;
                end else if (r_cnt == LP_LAST) begin
                    w_next = S_DONE;
                    w_fin  = 1'b1;
                    w_fail = 1'b1;
                end
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= 8'h0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_wmask   <= 4'h0;
            r_is_load <= 1'b0;
            r_f3      <= 3'h0;
            r_lane    <= 2'h0;
            r_err     <= 1'b0;
            r_rdata   <= 32'h0;
        end else begin
            r_err   <= w_fail;
            r_rdata <= w_rdata_nxt;
            if (w_launch) begin
                r_cnt     <= 8'h0;
                r_req     <= 1'b1;
                r_we      <= mem_write_in;
                r_addr    <= {addr_in[31:2], 2'b00};
                r_wdata   <= w_st_wdata;
                r_wmask   <= w_st_wmask;
                r_is_load <= mem_read_in;
                r_f3      <= funct3_in;
                r_lane    <= addr_in[1:0];
            end else if (w_fin) begin
                r_req   <= 1'b0;
                r_we    <= 1'b0;
                r_addr  <= 32'h0;
                r_wdata <= 32'h0;
                r_wmask <= 4'h0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wmask = r_wmask;
    assign stall_out = ((r_state == S_IDLE) & w_start) | (r_state == S_WAIT);
    assign done_out  = (r_state == S_DONE);
    assign err_out   = r_err;
    assign rdata_out = r_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset/idle sequences and
// randomized transactions checked against an arithmetic reference model.
module tb_mem_access_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [2:0]  funct3_in;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall_out;
    logic        done_out;
    logic [31:0] rdata_out;
    logic        err_out;

    int n_chk = 0;
    int n_err = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .funct3_in(funct3_in), .addr_in(addr_in), .wdata_in(wdata_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .stall_out(stall_out), .done_out(done_out),
        .rdata_out(rdata_out), .err_out(err_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        rd;
        bit        wr;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [31:0] rdata;
        int        dly;
        bit        ill;
        bit [31:0] eaddr;
        bit [31:0] ewd;
        bit [3:0]  emask;
        bit [31:0] erd;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void model(
        input bit rd, input bit wr, input bit [2:0] f3,
        input bit [31:0] a, input bit [31:0] wd, input bit [31:0] rdw,
        output bit ill, output bit [31:0] eaddr, output bit [31:0] ewd,
        output bit [3:0] emask, output bit [31:0] erd);
        int unsigned sz, lane;
        bit [31:0] m, v;
        sz = 1 << f3[1:0];
        lane = a % 4;
        ill = (rd && wr) || f3 == 3 || f3 == 6 || f3 == 7 || (wr && f3[2])
              || (a % sz != 0);
        eaddr = a - lane;
        ewd = 0;
        emask = 0;
        erd = 0;
        if (wr) begin
            if (sz == 1) ewd = (wd % 256) * 32'h01010101;
            else if (sz == 2) ewd = (wd % 65536) * 32'h00010001;
            else ewd = wd;
            emask = 4'(((1 << sz) - 1) << lane);
        end else begin
            m = (sz >= 4) ? 32'hFFFFFFFF : (32'h1 << (8 * sz)) - 1;
            v = (rdw >> (8 * lane)) & m;
            if (!f3[2] && sz < 4 && v > (m >> 1)) v = v | ~m;
            erd = v;
        end
    endfunction

    task automatic run_txn(
        input bit rd, input bit wr, input bit [2:0] f3,
        input bit [31:0] a, input bit [31:0] wd, input bit [31:0] rdw,
        input int dly, input bit ill, input bit [31:0] eaddr,
        input bit [31:0] ewd, input bit [3:0] emask, input bit [31:0] erd);
        int  stalls;
        int  reqs;
        bit  acked;
        bit  tmo;
        bit  exp_err;
        int  exp_stall;
        tmo = !ill && dly >= TMO;
        exp_err = ill || tmo;
        exp_stall = ill ? 1 : (tmo ? 1 + TMO : dly + 2);
        @(negedge clk);
        valid_in = 1'b1;
        mem_read_in = rd;
        mem_write_in = wr;
        funct3_in = f3;
        addr_in = a;
        wdata_in = wd;
        #1;
        stalls = int'(stall_out);
        reqs = 0;
        acked = 1'b0;
        @(negedge clk);
        valid_in = 1'b0;
        mem_read_in = 1'($urandom);
        mem_write_in = 1'($urandom);
        funct3_in = 3'($urandom);
        addr_in = $urandom;
        wdata_in = $urandom;
        if (!ill) begin
            for (int k = 0; k < TMO; k++) begin
                stalls += int'(stall_out);
                reqs += int'(mem_req);
                if (k == 0) begin
                    chk("bus_addr", mem_addr, eaddr);
                    chk("bus_we", 32'(mem_we), 32'(wr));
                    chk("bus_wmask", 32'(mem_wmask), 32'(emask));
                    if (wr) chk("bus_wdata", mem_wdata, ewd);
                    chk("done_in_wait", 32'(done_out), 0);
                end
                if (k == dly) begin
                    mem_ack = 1'b1;
                    mem_rdata = rdw;
                    acked = 1'b1;
                end else begin
                    mem_ack = 1'b0;
                    mem_rdata = $urandom;
                end
                @(negedge clk);
                mem_ack = 1'b0;
                if (acked) break;
            end
        end
        chk("done_pulse", 32'(done_out), 1);
        chk("err_out", 32'(err_out), 32'(exp_err));
        chk("rdata_out", rdata_out, (exp_err || wr) ? 32'h0 : erd);
        chk("stall_on_done", 32'(stall_out), 0);
        chk("req_on_done", 32'(mem_req), 0);
        chk("stall_cycles", 32'(stalls), 32'(exp_stall));
        chk("req_cycles", 32'(reqs), 32'(ill ? 0 : exp_stall - 1));
        @(negedge clk);
        chk("done_one_cycle", 32'(done_out), 0);
        chk("err_one_cycle", 32'(err_out), 0);
    endtask

    initial begin
        bit        r_rd, r_wr, r_ill;
        bit [2:0]  r_f3;
        bit [31:0] r_a, r_wd, r_rdw, r_eaddr, r_ewd, r_erd;
        bit [3:0]  r_emask;
        int        r_dly, sel;

        tbl[0]  = '{1, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 2, 0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF};
        tbl[1]  = '{1, 0, 3'b000, 32'h13, 32'h0, 32'h80FF0000, 0, 0, 32'h10, 32'h0, 4'b0000, 32'hFFFFFF80};
        tbl[2]  = '{1, 0, 3'b100, 32'h13, 32'h0, 32'h80FF0000, 0, 0, 32'h10, 32'h0, 4'b0000, 32'h00000080};
        tbl[3]  = '{0, 1, 3'b001, 32'h22, 32'h1234ABCD, 32'h0, 0, 0, 32'h20, 32'hABCDABCD, 4'b1100, 32'h0};
        tbl[4]  = '{1, 0, 3'b010, 32'h06, 32'h0, 32'h0, 0, 1, 32'h0, 32'h0, 4'b0000, 32'h0};
        tbl[5]  = '{0, 1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0, 9, 0, 32'h40, 32'hCAFEF00D, 4'b1111, 32'h0};
        tbl[6]  = '{1, 0, 3'b001, 32'h32, 32'h0, 32'h80017FFF, 1, 0, 32'h30, 32'h0, 4'b0000, 32'hFFFF8001};
        tbl[7]  = '{1, 0, 3'b101, 32'h30, 32'h0, 32'h1234F00D, 0, 0, 32'h30, 32'h0, 4'b0000, 32'h0000F00D};
        tbl[8]  = '{1, 0, 3'b001, 32'h31, 32'h0, 32'h0, 0, 1, 32'h0, 32'h0, 4'b0000, 32'h0};
        tbl[9]  = '{0, 1, 3'b000, 32'h51, 32'h000000A5, 32'h0, 1, 0, 32'h50, 32'hA5A5A5A5, 4'b0010, 32'h0};
        tbl[10] = '{1, 1, 3'b010, 32'h00, 32'h0, 32'h0, 0, 1, 32'h0, 32'h0, 4'b0000, 32'h0};
        tbl[11] = '{0, 1, 3'b100, 32'h00, 32'h0, 32'h0, 0, 1, 32'h0, 32'h0, 4'b0000, 32'h0};
        tbl[12] = '{1, 0, 3'b011, 32'h00, 32'h0, 32'h0, 0, 1, 32'h0, 32'h0, 4'b0000, 32'h0};
        tbl[13] = '{1, 0, 3'b010, 32'h08, 32'h0, 32'h11223344, 3, 0, 32'h08, 32'h0, 4'b0000, 32'h11223344};
        tbl[14] = '{1, 0, 3'b000, 32'h61, 32'h0, 32'h00007F00, 0, 0, 32'h60, 32'h0, 4'b0000, 32'h0000007F};

        rst = 1'b1;
        valid_in = 1'b0;
        mem_read_in = 1'b0;
        mem_write_in = 1'b0;
        funct3_in = 3'h0;
        addr_in = 32'h0;
        wdata_in = 32'h0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_wmask", 32'(mem_wmask), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_done", 32'(done_out), 0);
        chk("rst_err", 32'(err_out), 0);
        chk("rst_rdata", rdata_out, 0);
        chk("rst_stall", 32'(stall_out), 0);
        rst = 1'b0;

        // Non-memory instruction plus a stray ack in IDLE: nothing happens.
        @(negedge clk);
        valid_in = 1'b1;
        mem_ack = 1'b1;
        #1;
        chk("nonmem_stall", 32'(stall_out), 0);
        @(negedge clk);
        chk("nonmem_req", 32'(mem_req), 0);
        chk("nonmem_done", 32'(done_out), 0);
        valid_in = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("idle_ack_done", 32'(done_out), 0);

        for (int i = 0; i < 15; i++)
            run_txn(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].addr,
                    tbl[i].wdata, tbl[i].rdata, tbl[i].dly, tbl[i].ill,
                    tbl[i].eaddr, tbl[i].ewd, tbl[i].emask, tbl[i].erd);

        // Reset while waiting for the bus, then a late ack.
        @(negedge clk);
        valid_in = 1'b1;
        mem_read_in = 1'b1;
        mem_write_in = 1'b0;
        funct3_in = 3'b010;
        addr_in = 32'h70;
        @(negedge clk);
        valid_in = 1'b0;
        chk("mid_req_before_rst", 32'(mem_req), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_req_after_rst", 32'(mem_req), 0);
        chk("mid_stall_after_rst", 32'(stall_out), 0);
        chk("mid_done_after_rst", 32'(done_out), 0);
        mem_ack = 1'b1;
        mem_rdata = 32'h55AA55AA;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("late_ack_done", 32'(done_out), 0);
        chk("late_ack_req", 32'(mem_req), 0);
        run_txn(1, 0, 3'b010, 32'h74, 32'h0, 32'h0BADF00D, 1, 0,
                32'h74, 32'h0, 4'b0000, 32'h0BADF00D);

        for (int n = 0; n < 300; n++) begin
            sel = int'($urandom_range(0, 9));
            r_rd = (sel <= 5);
            r_wr = (sel == 0) || (sel >= 6);
            r_f3 = 3'($urandom);
            r_a = $urandom;
            r_wd = $urandom;
            r_rdw = $urandom;
            r_dly = int'($urandom_range(0, 5));
            model(r_rd, r_wr, r_f3, r_a, r_wd, r_rdw,
                  r_ill, r_eaddr, r_ewd, r_emask, r_erd);
            run_txn(r_rd, r_wr, r_f3, r_a, r_wd, r_rdw, r_dly,
                    r_ill, r_eaddr, r_ewd, r_emask, r_erd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
